// File: rtl/ifu_prefetch.sv
// Instruction prefetch unit: issues word reads to instruction memory, predecodes
// each returned word for a static branch prediction, and buffers the results in a
// small in-order queue. Taken predictions redirect fetch; flush overrides everything.
module ifu_prefetch #(
  parameter int               XLEN     = 32,
  parameter int               DEPTH    = 4,
  parameter int               ADDR_W   = 14,
  parameter logic [XLEN-1:0]  RESET_PC = {XLEN{1'b0}}
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_en,
  input  logic              flush_flag,
  input  logic [XLEN-1:0]   flush_addr,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_pc,
  output logic [31:0]       out_instr,
  output logic              out_pred_taken,
  output logic [XLEN-1:0]   out_pred_target
);

  localparam int              PTR_W      = $clog2(DEPTH);
  localparam logic [PTR_W:0]  DEPTH_C    = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]  CNT_ZERO   = {(PTR_W+1){1'b0}};
  localparam logic [PTR_W:0]  CNT_ONE    = (PTR_W+1)'(1'b1);
  localparam logic [PTR_W-1:0] PTR_ZERO  = {PTR_W{1'b0}};
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1'b1);
  localparam logic [XLEN-1:0] PC_STEP    = XLEN'(3'd4);
  localparam logic [XLEN-1:0] FLUSH_MASK = ~(XLEN'(2'b11));
  localparam logic [6:0]      OP_JAL     = 7'b1101111;
  localparam logic [6:0]      OP_BRANCH  = 7'b1100011;

  // Static prediction: JAL always taken, conditional branches taken when backward.
  function automatic logic pred_taken_f(input logic [31:0] instr);
    case (instr[6:0])
      OP_JAL:    pred_taken_f = 1'b1;
      OP_BRANCH: pred_taken_f = instr[31];
      default:   pred_taken_f = 1'b0;
    endcase
  endfunction

  // Predicted next PC; the sign-extended immediate wraps modulo 2^XLEN.
  function automatic logic [XLEN-1:0] pred_target_f(input logic [XLEN-1:0] pc,
                                                    input logic [31:0]     instr);
    logic [XLEN-1:0] j_imm;
    logic [XLEN-1:0] b_imm;
    j_imm = {{(XLEN-20){instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
    b_imm = {{(XLEN-12){instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
    case (instr[6:0])
      OP_JAL:    pred_target_f = pc + j_imm;
      OP_BRANCH: pred_target_f = instr[31] ? (pc + b_imm) : (pc + PC_STEP);
      default:   pred_target_f = pc + PC_STEP;
    endcase
  endfunction

  logic [XLEN-1:0]  fpc_r;
  logic [XLEN-1:0]  req_pc_r;
  logic             inflight_r;
  logic             squash_r;
  logic [PTR_W-1:0] head_r;
  logic [PTR_W-1:0] tail_r;
  logic [PTR_W:0]   count_r;

  logic [XLEN-1:0]  q_pc_r     [DEPTH];
  logic [31:0]      q_instr_r  [DEPTH];
  logic             q_taken_r  [DEPTH];
  logic [XLEN-1:0]  q_target_r [DEPTH];

  logic             req_s;
  logic             push_s;
  logic             pop_s;
  logic             valid_s;
  logic             resp_taken_s;
  logic [XLEN-1:0]  resp_target_s;
  logic             redirect_s;

  // Request gating, response predecode and queue handshake decisions.
  always_comb begin
    req_s         = rst && fetch_en && !flush_flag &&
                    ((count_r + {{PTR_W{1'b0}}, inflight_r}) < DEPTH_C);
    push_s        = rst && inflight_r && !squash_r && !flush_flag;
    valid_s       = rst && (count_r != CNT_ZERO);
    pop_s         = valid_s && out_ready && !flush_flag;
    resp_taken_s  = pred_taken_f(imem_rdata);
    resp_target_s = pred_target_f(req_pc_r, imem_rdata);
    redirect_s    = push_s && resp_taken_s;
  end

  assign imem_req  = req_s;
  assign imem_addr = fpc_r[ADDR_W+1:2];
  assign out_valid = valid_s;

  // Fetch PC, in-flight tracking and queue pointers; flush beats redirect beats +4.
  always_ff @(posedge clk) begin
    if (!rst) begin
      fpc_r      <= RESET_PC;
      req_pc_r   <= {XLEN{1'b0}};
      inflight_r <= 1'b0;
      squash_r   <= 1'b0;
      head_r     <= PTR_ZERO;
      tail_r     <= PTR_ZERO;
      count_r    <= CNT_ZERO;
    end else if (flush_flag) begin
      fpc_r      <= flush_addr & FLUSH_MASK;
      inflight_r <= 1'b0;
      squash_r   <= 1'b0;
      head_r     <= PTR_ZERO;
      tail_r     <= PTR_ZERO;
      count_r    <= CNT_ZERO;
    end else begin
      if (redirect_s) begin
        fpc_r <= resp_target_s;
      end else if (req_s) begin
        fpc_r <= fpc_r + PC_STEP;
      end
      if (req_s) begin
        req_pc_r <= fpc_r;
      end
      inflight_r <= req_s;
      squash_r   <= req_s && redirect_s;
      if (push_s) begin
        tail_r <= tail_r + PTR_ONE;
      end
      if (pop_s) begin
        head_r <= head_r + PTR_ONE;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  // Store the predecoded response in the tail slot.
  always_ff @(posedge clk) begin
    if (push_s) begin
      q_pc_r[tail_r]     <= req_pc_r;
      q_instr_r[tail_r]  <= imem_rdata;
      q_taken_r[tail_r]  <= resp_taken_s;
      q_target_r[tail_r] <= resp_target_s;
    end
  end

  // Present the head entry, or zeros while the queue is empty or in reset.
  always_comb begin
    if (valid_s) begin
      out_pc          = q_pc_r[head_r];
      out_instr       = q_instr_r[head_r];
      out_pred_taken  = q_taken_r[head_r];
      out_pred_target = q_target_r[head_r];
    end else begin
      out_pc          = {XLEN{1'b0}};
      out_instr       = 32'h0000_0000;
      out_pred_taken  = 1'b0;
      out_pred_target = {XLEN{1'b0}};
    end
  end

endmodule
